// File: rtl/mawg_pkg.sv
// Shared types and constants for the multi-channel waveform generator.
// Holds the waveform mode encoding, config field codes and the sine table builder.
package mawg_pkg;

   typedef enum logic [1:0] {
      MODE_SINE  = 2'd0,
      MODE_SAW   = 2'd1,
      MODE_PULSE = 2'd2,
      MODE_TRI   = 2'd3
   } mode_e;

   localparam logic [2:0] FIELD_FREQ      = 3'd0;
   localparam logic [2:0] FIELD_PHASE_OFF = 3'd1;
   localparam logic [2:0] FIELD_DUTY      = 3'd2;
   localparam logic [2:0] FIELD_MODE      = 3'd3;
   localparam logic [2:0] FIELD_AMP       = 3'd4;
   localparam logic [2:0] FIELD_SYNC      = 3'd5;

   // Quarter-wave entry i = round(MAX * sin(pi/2 * (i+0.5) / 2^lut_aw)), sine by Taylor series.
   function automatic int sine_lut_entry(input int idx, input int lut_aw, input int out_w);
      real x;
      real term;
      real sum;
      real max_v;
      x     = 3.14159265358979 / 2.0 * (real'(idx) + 0.5) / real'(1 << lut_aw);
      sum   = x;
      term  = x;
      for (int k = 1; k < 12; k++) begin
         term = -term * x * x / real'((2 * k) * (2 * k + 1));
         sum  = sum + term;
      end
      max_v = real'((1 << (out_w - 1)) - 1);
      return $rtoi(max_v * sum + 0.5);
   endfunction

endpackage

// File: rtl/multi_wave_generator_channel.sv
// One generator channel: active config, phase accumulator, shaper and amplitude scaler.
// Three register stages: accumulator -> shaped sample -> scaled output.
module wave_channel
   import mawg_pkg::*;
#(
   parameter int PHASE_W = 32,
   parameter int OUT_W   = 16,
   parameter int AMP_W   = 12,
   parameter int LUT_AW  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               commit,
   input  logic [PHASE_W-1:0] sh_freq,
   input  logic [PHASE_W-1:0] sh_phase_off,
   input  logic [PHASE_W-1:0] sh_duty,
   input  mode_e              sh_mode,
   input  logic [AMP_W-1:0]   sh_amp,
   input  logic               sh_sync_en,
   output logic [OUT_W-1:0]   wave
);

   localparam logic [OUT_W-1:0] POS_MAX    = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] NEG_MAX    = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};
   localparam logic [OUT_W-1:0] MIN_S      = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [AMP_W-1:0] AMP_UNITY  = {1'b1, {(AMP_W-1){1'b0}}};

   typedef logic [OUT_W-2:0] lut_word_t;

   logic [PHASE_W-1:0] freq;
   logic [PHASE_W-1:0] phase_off;
   logic [PHASE_W-1:0] duty;
   mode_e              mode;
   logic [AMP_W-1:0]   amp;

   logic [PHASE_W-1:0] acc;
   logic [OUT_W-1:0]   shape_q;
   logic [OUT_W-1:0]   wave_q;

   lut_word_t          lut [1 << LUT_AW];

   logic [PHASE_W-1:0]        p;
   logic [OUT_W-1:0]          t;
   logic [LUT_AW-1:0]         lut_idx;
   logic [OUT_W-1:0]          mag;
   logic [OUT_W-1:0]          sine;
   logic [OUT_W-1:0]          shape;
   logic [AMP_W-1:0]          amp_c;
   logic signed [OUT_W+AMP_W:0] prod;
   logic [OUT_W-1:0]          wave_d;

   for (genvar i = 0; i < (1 << LUT_AW); i++) begin : g_lut
      localparam int ENTRY = sine_lut_entry(i, LUT_AW, OUT_W);
      assign lut[i] = lut_word_t'(ENTRY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         freq      <= '0;
         phase_off <= '0;
         duty      <= '0;
         mode      <= MODE_SINE;
         amp       <= '0;
      end else if (commit) begin
         freq      <= sh_freq;
         phase_off <= sh_phase_off;
         duty      <= sh_duty;
         mode      <= sh_mode;
         amp       <= sh_amp;
      end
   end

   // A sync clear wins over the accumulate step, even while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (commit && sh_sync_en) begin
         acc <= '0;
      end else if (enable) begin
         acc <= acc + freq;
      end
   end

   always_comb begin
      p       = acc + phase_off;
      t       = p[PHASE_W-1 -: OUT_W];
      lut_idx = p[PHASE_W-3 -: LUT_AW];
      if (p[PHASE_W-2]) begin
         lut_idx = ~lut_idx;
      end
      mag  = {1'b0, lut[lut_idx]};
      sine = p[PHASE_W-1] ? (~mag + OUT_W'(1)) : mag;
      shape = '0;
      case (mode)
         MODE_SINE:  shape = sine;
         MODE_SAW:   shape = {~t[OUT_W-1], t[OUT_W-2:0]};
         MODE_PULSE: shape = (p < duty) ? POS_MAX : NEG_MAX;
         MODE_TRI:   shape = {(t[OUT_W-1] ? ~t[OUT_W-2:0] : t[OUT_W-2:0]), 1'b0} ^ MIN_S;
         default:    shape = '0;
      endcase
   end

   always_comb begin
      amp_c  = (amp > AMP_UNITY) ? AMP_UNITY : amp;
      prod   = $signed(shape_q) * $signed({1'b0, amp_c});
      wave_d = OUT_W'(prod >>> (AMP_W - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shape_q <= '0;
         wave_q  <= '0;
      end else if (enable) begin
         shape_q <= shape;
         wave_q  <= wave_d;
      end
   end

   assign wave = wave_q;

endmodule

// File: rtl/multi_wave_generator.sv
// N-channel waveform generator: shadow config registers, write handshake, coherent commit
// to every channel at once, and the output valid pipeline.
module multi_wave_generator
   import mawg_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int PHASE_W = 32,
   parameter int OUT_W   = 16,
   parameter int AMP_W   = 12,
   parameter int LUT_AW  = 8,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [CH_W-1:0]         cfg_chan,
   input  logic [2:0]              cfg_field,
   input  logic [PHASE_W-1:0]      cfg_data,
   input  logic                    commit,
   output logic [NUM_CH*OUT_W-1:0] wave_out,
   output logic                    wave_valid
);

   logic [PHASE_W-1:0] sh_freq      [NUM_CH];
   logic [PHASE_W-1:0] sh_phase_off [NUM_CH];
   logic [PHASE_W-1:0] sh_duty      [NUM_CH];
   mode_e              sh_mode      [NUM_CH];
   logic [AMP_W-1:0]   sh_amp       [NUM_CH];
   logic               sh_sync_en   [NUM_CH];

   logic               ready_q;
   logic [2:0]         valid_pipe;

   // Handshake: a write is taken on any edge where cfg_valid && cfg_ready; cfg_valid may
   // stay high while waiting. cfg_ready is registered, low during reset and for the one
   // cycle after each commit, independent of cfg_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= !commit;
      end
   end

   assign cfg_ready = ready_q;

   // Unknown fields and out-of-range channels are consumed without touching any register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            sh_freq[ch]      <= '0;
            sh_phase_off[ch] <= '0;
            sh_duty[ch]      <= '0;
            sh_mode[ch]      <= MODE_SINE;
            sh_amp[ch]       <= '0;
            sh_sync_en[ch]   <= 1'b0;
         end
      end else if (cfg_valid && ready_q) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (cfg_chan == CH_W'(ch)) begin
               case (cfg_field)
                  FIELD_FREQ:      sh_freq[ch]      <= cfg_data;
                  FIELD_PHASE_OFF: sh_phase_off[ch] <= cfg_data;
                  FIELD_DUTY:      sh_duty[ch]      <= cfg_data;
                  FIELD_MODE:      sh_mode[ch]      <= mode_e'(cfg_data[1:0]);
                  FIELD_AMP:       sh_amp[ch]       <= cfg_data[AMP_W-1:0];
                  FIELD_SYNC:      sh_sync_en[ch]   <= cfg_data[0];
                  default:         ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_pipe <= '0;
      end else begin
         valid_pipe <= {valid_pipe[1:0], enable};
      end
   end

   assign wave_valid = valid_pipe[2] && enable;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      wave_channel #(
         .PHASE_W (PHASE_W),
         .OUT_W   (OUT_W),
         .AMP_W   (AMP_W),
         .LUT_AW  (LUT_AW)
      ) u_ch (
         .clk          (clk),
         .rst_n        (rst_n),
         .enable       (enable),
         .commit       (commit),
         .sh_freq      (sh_freq[k]),
         .sh_phase_off (sh_phase_off[k]),
         .sh_duty      (sh_duty[k]),
         .sh_mode      (sh_mode[k]),
         .sh_amp       (sh_amp[k]),
         .sh_sync_en   (sh_sync_en[k]),
         .wave         (wave_out[k*OUT_W +: OUT_W])
      );
   end

endmodule
